// File: rtl/matrix_pkg.sv
// Shared types and helpers for the 5x7 LED matrix scan path.
// Holds default geometry, capture FSM states and the column strobe decoder.
package matrix_pkg;

  localparam int N_COLS_DEF = 7;
  localparam int N_ROWS_DEF = 5;
  localparam int MAX_COLS   = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    SYNC,
    CAPTURE,
    PUBLISH
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             idle;
    logic [IDX_W-1:0] index;
  } col_dec_t;

  // Unused upper strobes must be tied high by the caller.
  function automatic col_dec_t onehot_n_decode(
    input logic [MAX_COLS-1:0] col_n
  );
    col_dec_t d;
    int lows;
    d    = '0;
    lows = 0;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (!col_n[i]) begin
        lows++;
        d.index = IDX_W'(i);
      end
    end
    d.idle  = (lows == 0);
    d.valid = (lows == 1);
    return d;
  endfunction

endpackage

// File: rtl/scan_settle_filter.sv
// Synchroniser, change detector and settle counter for col_n/row.
// Ports: col_n,row in; stable_pulse, col_valid, col_idle, col_idx, row_s out.
module scan_settle_filter
  import matrix_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int N_ROWS = N_ROWS_DEF,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COLS-1:0] col_n,
  input  logic [N_ROWS-1:0] row,
  output logic              stable_pulse,
  output logic              col_valid,
  output logic              col_idle,
  output logic [IDX_W-1:0]  col_idx,
  output logic [N_ROWS-1:0] row_s
);

  localparam int W = N_COLS + N_ROWS;
  localparam logic [3:0] CNT_MAX = 4'(SETTLE - 1);
  localparam logic [W-1:0] IDLE =
    {{N_COLS{1'b1}}, {N_ROWS{1'b0}}};

  logic [W-1:0] s1, s2, prev;
  logic [3:0]   cnt;
  logic         accepted;
  logic         same;
  logic         col_chg;
  col_dec_t     dec;

  assign same    = (s2 == prev);
  assign col_chg = (s2[W-1:N_ROWS] != prev[W-1:N_ROWS]);

  // One acceptance per column visit; a row change alone does not rearm.
  assign stable_pulse =
    same && (cnt == CNT_MAX) && !accepted;

  assign dec = onehot_n_decode(
    {{(MAX_COLS-N_COLS){1'b1}}, s2[W-1:N_ROWS]});

  assign col_valid = dec.valid;
  assign col_idle  = dec.idle;
  assign col_idx   = dec.index;
  assign row_s     = s2[N_ROWS-1:0];

  // Sync flops reset to the idle pattern so reset is not seen as a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= IDLE;
      s2       <= IDLE;
      prev     <= IDLE;
      cnt      <= '0;
      accepted <= 1'b0;
    end else begin
      s1   <= {col_n, row};
      s2   <= s1;
      prev <= s2;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 4'd1;
      if (col_chg)
        accepted <= 1'b0;
      else if (stable_pulse)
        accepted <= 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds a full LED matrix frame from the scan strobes and row lines.
// Ports: col_n,row in; frame/frame_valid/frame_ready handshake; scan_err, overrun.
module matrix_scan_capture
  import matrix_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int N_ROWS = N_ROWS_DEF,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_COLS-1:0]        col_n,
  input  logic [N_ROWS-1:0]        row,
  output logic [N_COLS*N_ROWS-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     scan_err,
  output logic                     overrun
);

  localparam int FW = N_COLS * N_ROWS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_COLS - 1);

  logic              stable;
  logic              c_valid;
  logic              c_idle;
  logic [IDX_W-1:0]  c_idx;
  logic [N_ROWS-1:0] row_s;

  state_t           state;
  logic [IDX_W-1:0] expected;
  logic [FW-1:0]    shadow;
  logic             hit;
  logic             again;

  scan_settle_filter #(
    .N_COLS (N_COLS),
    .N_ROWS (N_ROWS),
    .SETTLE (SETTLE)
  ) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_n        (col_n),
    .row          (row),
    .stable_pulse (stable),
    .col_valid    (c_valid),
    .col_idle     (c_idle),
    .col_idx      (c_idx),
    .row_s        (row_s)
  );

  assign hit   = c_valid && (c_idx == expected);
  assign again = c_valid && (c_idx == expected - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      expected    <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      scan_err <= 1'b0;
      if (frame_valid && frame_ready)
        frame_valid <= 1'b0;
      unique case (state)
        SYNC: begin
          if (stable) begin
            if (!c_valid && !c_idle) begin
              scan_err <= 1'b1;
            end else if (c_valid && c_idx == '0) begin
              shadow[N_ROWS-1:0] <= row_s;
              expected <= IDX_W'(1);
              state    <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (stable && !c_idle) begin
            unique case (1'b1)
              hit: begin
                shadow[c_idx*N_ROWS +: N_ROWS] <= row_s;
                expected <= expected + 1'b1;
                if (c_idx == LAST)
                  state <= PUBLISH;
              end
              again: ;
              default: begin
                scan_err <= 1'b1;
                expected <= '0;
                state    <= SYNC;
              end
            endcase
          end
        end
        PUBLISH: begin
          // A consumer taking the old frame this cycle frees the slot.
          if (!frame_valid || frame_ready) begin
            frame       <= shadow;
            frame_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          expected <= '0;
          state    <= SYNC;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture.
// Drives strobe sequences on the falling edge and checks outputs there.
module tb_matrix_scan_capture;

  localparam int SETTLE = 2;
  localparam int HOLD   = SETTLE + 3;
  localparam int BLANK  = 3;
  localparam int LAT    = 2 + SETTLE + 2;

  // Columns 6..0: 1F,00,1F,00,1D,15,17
  localparam logic [34:0] EXP1 =
    {5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1D, 5'h15, 5'h17};
  localparam logic [34:0] EXP2 = ~EXP1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  col_n = 7'h7F;
  logic [4:0]  row = 5'h00;
  logic        frame_ready = 1'b1;
  logic [34:0] frame;
  logic        frame_valid;
  logic        scan_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int fv_rises = 0;
  int err_pulses = 0;
  logic fv_q = 1'b0;

  always #5 clk = ~clk;

  matrix_scan_capture #(
    .N_COLS (7),
    .N_ROWS (5),
    .SETTLE (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .row         (row),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .scan_err    (scan_err),
    .overrun     (overrun)
  );

  always @(negedge clk) begin
    if (frame_valid && !fv_q) fv_rises++;
    fv_q = frame_valid;
    if (scan_err) err_pulses++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input int c);
    logic [6:0] one;
    one = 7'd1;
    col_n = ~(one << c);
  endtask

  task automatic show_col(input int c, input logic [4:0] r);
    strobe(c);
    row = r;
    repeat (HOLD) @(negedge clk);
    col_n = 7'h7F;
    row = 5'h00;
    repeat (BLANK) @(negedge clk);
  endtask

  task automatic scan(input logic [34:0] f);
    for (int c = 0; c < 7; c++)
      show_col(c, f[c*5 +: 5]);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int b_fv;
  int b_err;
  int lat;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_err", 64'(scan_err), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic scan with latency measurement on the last column
    b_fv = fv_rises; b_err = err_pulses;
    frame_ready = 1'b1;
    for (int c = 0; c < 6; c++)
      show_col(c, EXP1[c*5 +: 5]);
    lat = -1;
    strobe(6);
    row = EXP1[30 +: 5];
    for (int i = 1; i <= HOLD + BLANK + 2; i++) begin
      if (i == HOLD + 1) begin
        col_n = 7'h7F;
        row = 5'h00;
      end
      @(negedge clk);
      if (frame_valid && lat < 0) lat = i;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("t1_frame", 64'(frame), 64'(EXP1));
    for (int c = 0; c < 7; c++)
      check($sformatf("t1_col%0d", c),
            64'(frame[c*5 +: 5]), 64'(EXP1[c*5 +: 5]));
    check("t1_valid_drop", 64'(frame_valid), 64'd0);
    check("t1_pulses", 64'(fv_rises - b_fv), 64'd1);
    check("t1_err", 64'(err_pulses - b_err), 64'd0);

    // Backpressure and overrun
    frame_ready = 1'b0;
    scan(EXP1);
    check("t2_valid1", 64'(frame_valid), 64'd1);
    check("t2_ovr0", 64'(overrun), 64'd0);
    scan(EXP2);
    check("t2_hold", 64'(frame), 64'(EXP1));
    check("t2_ovr1", 64'(overrun), 64'd1);
    check("t2_valid2", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("t2_drop", 64'(frame_valid), 64'd0);
    check("t2_ovr_sticky", 64'(overrun), 64'd1);

    // Late start: 3,4 before column 0
    do_reset();
    check("t3_ovr_clr", 64'(overrun), 64'd0);
    b_fv = fv_rises; b_err = err_pulses;
    show_col(3, 5'h0A);
    show_col(4, 5'h0B);
    check("t3_no_early", 64'(fv_rises - b_fv), 64'd0);
    scan(EXP1);
    check("t3_pulses", 64'(fv_rises - b_fv), 64'd1);
    check("t3_err", 64'(err_pulses - b_err), 64'd0);
    check("t3_frame", 64'(frame), 64'(EXP1));

    // Skipped column
    b_fv = fv_rises; b_err = err_pulses;
    show_col(0, 5'h01);
    show_col(1, 5'h02);
    show_col(3, 5'h04);
    check("t4_err", 64'(err_pulses - b_err), 64'd1);
    check("t4_no_frame", 64'(fv_rises - b_fv), 64'd0);
    scan(EXP2);
    check("t4_pulses", 64'(fv_rises - b_fv), 64'd1);
    check("t4_frame", 64'(frame), 64'(EXP2));

    // Two strobes low at once
    b_err = err_pulses;
    col_n = 7'b1110011;
    row = 5'h1F;
    repeat (6) @(negedge clk);
    col_n = 7'h7F;
    row = 5'h00;
    repeat (BLANK) @(negedge clk);
    check("t5_multi", 64'(err_pulses - b_err), 64'd1);

    // One-cycle row glitch at the start of column 2
    b_fv = fv_rises;
    show_col(0, EXP1[0 +: 5]);
    show_col(1, EXP1[5 +: 5]);
    strobe(2);
    row = 5'h02;
    @(negedge clk);
    row = EXP1[10 +: 5];
    repeat (HOLD) @(negedge clk);
    col_n = 7'h7F;
    row = 5'h00;
    repeat (BLANK) @(negedge clk);
    for (int c = 3; c < 7; c++)
      show_col(c, EXP1[c*5 +: 5]);
    repeat (4) @(negedge clk);
    check("t5_col2", 64'(frame[10 +: 5]), 64'h1D);
    check("t5_frame", 64'(frame), 64'(EXP1));
    check("t5_pulses", 64'(fv_rises - b_fv), 64'd1);

    // Reset mid-frame with valid and overrun set
    frame_ready = 1'b0;
    scan(EXP2);
    scan(EXP1);
    check("t6_pre_ovr", 64'(overrun), 64'd1);
    for (int c = 0; c < 4; c++)
      show_col(c, 5'h11);
    strobe(4);
    row = 5'h11;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_frame", 64'(frame), 64'd0);
    check("t6_valid", 64'(frame_valid), 64'd0);
    check("t6_ovr", 64'(overrun), 64'd0);
    col_n = 7'h7F;
    row = 5'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    b_fv = fv_rises;
    scan(EXP2);
    check("t6_frame2", 64'(frame), 64'(EXP2));
    check("t6_pulses", 64'(fv_rises - b_fv), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
